// File: rtl/dac_pkg.sv
// Shared types and constants for the SPI DAC serializer.
package dac_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

    // Command prefixes: write and update the addressed DAC channel.
    localparam logic [7:0] CmdDacA = 8'h30;
    localparam logic [7:0] CmdDacB = 8'h31;

    function automatic int unsigned frame_w(input int unsigned cmd_w, input int unsigned data_w);
        return cmd_w + data_w;
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer for SCLK: ticks every HALF_DIV cycles while enabled,
// restarted by the FSM whenever it changes state.
module spi_half_tick #(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CNT_W'(HALF_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_spi_serializer.sv
// Ships each compute-stage sample to an SPI DAC as {CMD_WORD, sample}, MSB first, mode 0,
// with a one-deep holding register and a saturating overrun counter.
module dac_spi_serializer
    import dac_pkg::*;
#(
    parameter int unsigned      DATA_W      = 16,
    parameter int unsigned      CMD_W       = 8,
    parameter logic [CMD_W-1:0] CMD_WORD    = CmdDacA,
    parameter int unsigned      HALF_DIV    = 4,
    parameter int unsigned      MIN_CS_HIGH = 4,
    parameter bit               OFFSET_BIN  = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    input  logic              enable,
    input  logic              clear_overrun,
    output logic              dac_cs_n,
    output logic              dac_sclk,
    output logic              dac_mosi,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       overrun_cnt
);

    localparam int unsigned FRAME_W = frame_w(CMD_W, DATA_W);
    localparam int unsigned CNT_MAX = (FRAME_W > MIN_CS_HIGH) ? FRAME_W : MIN_CS_HIGH;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                cs_n_q, cs_n_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic [15:0]         overrun_cnt_q, overrun_cnt_d;

    logic [DATA_W-1:0]   load_sample;
    logic [FRAME_W-1:0]  load_frame;
    logic                drain, write, overrun;
    logic                tick, tick_en, restart;

    // Offset-binary conversion happens on the way into the shifter, so hold keeps the raw sample.
    always_comb begin
        load_sample = hold_q;
        if (OFFSET_BIN) begin
            load_sample[DATA_W-1] = ~hold_q[DATA_W-1];
        end
    end

    assign load_frame = {CMD_WORD, load_sample};
    assign tick_en    = (state_q != StIdle);
    assign restart    = (state_d != state_q);

    spi_half_tick #(
        .HALF_DIV (HALF_DIV)
    ) u_half_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (tick_en),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        cs_n_d        = cs_n_q;
        sclk_d        = sclk_q;
        mosi_d        = mosi_q;
        frame_done_d  = 1'b0;
        overrun_cnt_d = overrun_cnt_q;
        drain         = 1'b0;

        case (state_q)
            StIdle: begin
                if (hold_full_q) begin
                    drain       = 1'b1;
                    hold_full_d = 1'b0;
                    state_d     = StSetup;
                    shift_d     = load_frame;
                    mosi_d      = load_frame[FRAME_W-1];
                    cs_n_d      = 1'b0;
                    bit_cnt_d   = '0;
                end
            end
            StSetup: begin
                if (tick) state_d = StShift;
            end
            StShift: begin
                if (tick) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                            state_d = StHold;
                        end else begin
                            shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
                            mosi_d    = shift_q[FRAME_W-2];
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
            end
            StHold: begin
                if (tick) begin
                    state_d      = StGap;
                    cs_n_d       = 1'b1;
                    frame_done_d = 1'b1;
                    mosi_d       = 1'b0;
                    bit_cnt_d    = '0;
                end
            end
            StGap: begin
                if (bit_cnt_q == CNT_W'(MIN_CS_HIGH - 1)) begin
                    state_d = StIdle;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A write in the drain cycle refills hold behind the outgoing sample; not an overrun.
        write   = sample_valid && enable;
        overrun = write && hold_full_q && !drain;
        if (write) begin
            hold_d      = sample;
            hold_full_d = 1'b1;
        end

        if (clear_overrun) begin
            overrun_cnt_d = overrun ? 16'd1 : 16'd0;
        end else if (overrun && (overrun_cnt_q != 16'hFFFF)) begin
            overrun_cnt_d = overrun_cnt_q + 16'd1;
        end

        busy_d = (state_d != StIdle) || hold_full_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            cs_n_q        <= 1'b1;
            sclk_q        <= 1'b0;
            mosi_q        <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            overrun_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            cs_n_q        <= cs_n_d;
            sclk_q        <= sclk_d;
            mosi_q        <= mosi_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign dac_cs_n    = cs_n_q;
    assign dac_sclk    = sclk_q;
    assign dac_mosi    = mosi_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Bench for dac_spi_serializer: two-complement and offset-binary instances share stimulus;
// a bus monitor decodes SPI frames into queues checked against expected frames.
module tb_dac_spi_serializer;

    localparam int HD      = 2;
    localparam int MCH     = 4;
    localparam int FW      = 24;
    localparam int LOW_CYC = HD * (2 * FW + 2);

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] sample = '0;
    logic        sample_valid = 1'b0;
    logic        enable = 1'b0;
    logic        clear_overrun = 1'b0;

    logic        cs_n, sclk, mosi, busy, frame_done;
    logic [15:0] ovr;
    logic        cs_n_ob, sclk_ob, mosi_ob, busy_ob, fd_ob;
    logic [15:0] ovr_ob;

    int vecs = 0;
    int errs = 0;

    logic [23:0] exp_q[$], exp_ob_q[$], rx_q[$], rx_ob_q[$];
    int          bits_q[$], low_q[$], gap_q[$];

    always #5 clk = ~clk;

    dac_spi_serializer #(
        .HALF_DIV    (HD),
        .MIN_CS_HIGH (MCH),
        .OFFSET_BIN  (1'b0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sample        (sample),
        .sample_valid  (sample_valid),
        .enable        (enable),
        .clear_overrun (clear_overrun),
        .dac_cs_n      (cs_n),
        .dac_sclk      (sclk),
        .dac_mosi      (mosi),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun_cnt   (ovr)
    );

    dac_spi_serializer #(
        .HALF_DIV    (HD),
        .MIN_CS_HIGH (MCH),
        .OFFSET_BIN  (1'b1)
    ) dut_ob (
        .clk           (clk),
        .reset_n       (reset_n),
        .sample        (sample),
        .sample_valid  (sample_valid),
        .enable        (enable),
        .clear_overrun (clear_overrun),
        .dac_cs_n      (cs_n_ob),
        .dac_sclk      (sclk_ob),
        .dac_mosi      (mosi_ob),
        .busy          (busy_ob),
        .frame_done    (fd_ob),
        .overrun_cnt   (ovr_ob)
    );

    // SPI bus monitor, sampled mid-cycle: mosi captured on each sclk rise while cs_n is low.
    logic [23:0] word = '0, word_ob = '0;
    int          bits = 0, low_cyc = 0, high_cyc = 0, fd_cnt = 0, fd_rise_cnt = 0;
    logic        cs_prev = 1'b1, sclk_prev = 1'b0, cs_prev_ob = 1'b1, sclk_prev_ob = 1'b0;

    always @(negedge clk) begin
        if (!reset_n) begin
            bits = 0; low_cyc = 0; high_cyc = 0; word = '0; word_ob = '0;
        end else begin
            if (cs_n && !cs_prev) begin
                rx_q.push_back(word); bits_q.push_back(bits); low_q.push_back(low_cyc);
                if (frame_done) fd_rise_cnt++;
                high_cyc = 0;
            end
            if (!cs_n && cs_prev) begin
                gap_q.push_back(high_cyc); low_cyc = 0; bits = 0;
            end
            if (!cs_n) begin
                low_cyc++;
                if (sclk && !sclk_prev) begin word = {word[22:0], mosi}; bits++; end
            end else begin
                high_cyc++;
            end
            if (frame_done) fd_cnt++;
            if (cs_n_ob && !cs_prev_ob) rx_ob_q.push_back(word_ob);
            if (!cs_n_ob && sclk_ob && !sclk_prev_ob) word_ob = {word_ob[22:0], mosi_ob};
        end
        cs_prev = cs_n; sclk_prev = sclk; cs_prev_ob = cs_n_ob; sclk_prev_ob = sclk_ob;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] s, input logic clr);
        sample = s; sample_valid = 1'b1; clear_overrun = clr;
        @(posedge clk); #1;
        sample_valid = 1'b0; clear_overrun = 1'b0;
    endtask

    task automatic expect_frame(input logic [15:0] s);
        exp_q.push_back({8'h30, s});
        exp_ob_q.push_back({8'h30, ~s[15], s[14:0]});
    endtask

    task automatic flush();
        exp_q.delete(); exp_ob_q.delete(); rx_q.delete(); rx_ob_q.delete();
        bits_q.delete(); low_q.delete(); gap_q.delete();
    endtask

    task automatic wait_frames(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (rx_q.size() >= n && rx_ob_q.size() >= n) begin ok = 1'b1; break; end
            tick(1);
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        vecs++; if (cs_n !== 1'b1) begin errs++; $display("FAIL reset cs_n: got %b, want 1", cs_n); end
        vecs++; if (sclk !== 1'b0) begin errs++; $display("FAIL reset sclk: got %b, want 0", sclk); end
        vecs++; if (mosi !== 1'b0) begin errs++; $display("FAIL reset mosi: got %b, want 0", mosi); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset busy: got %b, want 0", busy); end
        vecs++; if (frame_done !== 1'b0) begin errs++; $display("FAIL reset frame_done: got %b, want 0", frame_done); end
        vecs++; if (ovr !== 16'h0) begin errs++; $display("FAIL reset overrun_cnt: got %h, want 0000", ovr); end
        vecs++; if (cs_n_ob !== 1'b1) begin errs++; $display("FAIL reset ob cs_n: got %b, want 1", cs_n_ob); end
        vecs++; if ({busy_ob, fd_ob, ovr_ob} !== 18'h0) begin
            errs++; $display("FAIL reset ob busy/fd/ovr: got %b/%b/%h, want 0/0/0000", busy_ob, fd_ob, ovr_ob);
        end
        tick(2);
        reset_n = 1'b1; enable = 1'b1;
        tick(2);
    endtask

    task automatic test_single();
        logic [23:0] e, g;
        bit ok;
        int fd0, fr0, b, l;
        flush(); fd0 = fd_cnt; fr0 = fd_rise_cnt;
        strobe(16'hA5C3, 1'b0);
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL single busy N+1: got %b, want 1", busy); end
        vecs++; if (cs_n !== 1'b1) begin errs++; $display("FAIL single cs_n N+1: got %b, want 1", cs_n); end
        tick(1);
        vecs++; if (cs_n !== 1'b0) begin errs++; $display("FAIL single cs_n N+2: got %b, want 0", cs_n); end
        expect_frame(16'hA5C3);
        wait_frames(1, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL single timeout: got no frame, want 1"); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); vecs++;
            if (g !== e) begin errs++; $display("FAIL single word: got %h, want %h", g, e); end
        end
        while (exp_ob_q.size() > 0 && rx_ob_q.size() > 0) begin
            e = exp_ob_q.pop_front(); g = rx_ob_q.pop_front(); vecs++;
            if (g !== e) begin errs++; $display("FAIL single ob word: got %h, want %h", g, e); end
        end
        if (bits_q.size() > 0) begin
            b = bits_q.pop_front(); l = low_q.pop_front();
            vecs++; if (b != FW) begin errs++; $display("FAIL single rises: got %0d, want %0d", b, FW); end
            vecs++; if (l != LOW_CYC) begin errs++; $display("FAIL single cs low cycles: got %0d, want %0d", l, LOW_CYC); end
        end
        tick(MCH + 3);
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL single busy after gap: got %b, want 0", busy); end
        vecs++; if (fd_cnt - fd0 != 1) begin errs++; $display("FAIL single frame_done pulses: got %0d, want 1", fd_cnt - fd0); end
        vecs++; if (fd_rise_cnt - fr0 != 1) begin errs++; $display("FAIL single frame_done at cs rise: got %0d, want 1", fd_rise_cnt - fr0); end
    endtask

    task automatic test_offset();
        logic [23:0] e, g;
        bit ok;
        tick(10); flush();
        strobe(16'h8000, 1'b0); expect_frame(16'h8000);
        tick(5);
        strobe(16'h7FFF, 1'b0); expect_frame(16'h7FFF);
        wait_frames(2, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL offset timeout: got %0d frames, want 2", rx_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); vecs++;
            if (g !== e) begin errs++; $display("FAIL offset word: got %h, want %h", g, e); end
        end
        while (exp_ob_q.size() > 0 && rx_ob_q.size() > 0) begin
            e = exp_ob_q.pop_front(); g = rx_ob_q.pop_front(); vecs++;
            if (g !== e) begin errs++; $display("FAIL offset ob word: got %h, want %h", g, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] e, g;
        bit ok;
        tick(20); flush();
        strobe(16'h1357, 1'b0); expect_frame(16'h1357);
        tick(9);
        strobe(16'h2468, 1'b0); expect_frame(16'h2468);
        wait_frames(2, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL b2b timeout: got %0d frames, want 2", rx_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); vecs++;
            if (g !== e) begin errs++; $display("FAIL b2b word: got %h, want %h", g, e); end
        end
        while (exp_ob_q.size() > 0 && rx_ob_q.size() > 0) begin
            e = exp_ob_q.pop_front(); g = rx_ob_q.pop_front(); vecs++;
            if (g !== e) begin errs++; $display("FAIL b2b ob word: got %h, want %h", g, e); end
        end
        vecs++;
        if (gap_q.size() < 2) begin
            errs++; $display("FAIL b2b gap count: got %0d, want 2", gap_q.size());
        end else if (gap_q[1] != MCH + 1) begin
            errs++; $display("FAIL b2b cs high gap: got %0d, want %0d", gap_q[1], MCH + 1);
        end
        vecs++; if (ovr !== 16'h0) begin errs++; $display("FAIL b2b overrun_cnt: got %h, want 0000", ovr); end
    endtask

    task automatic test_overrun();
        logic [23:0] e, g;
        bit ok;
        tick(20); flush();
        strobe(16'h1111, 1'b0); expect_frame(16'h1111);
        tick(9);
        strobe(16'h2222, 1'b0);
        tick(9);
        strobe(16'h3333, 1'b0); expect_frame(16'h3333);
        vecs++; if (ovr !== 16'd1) begin errs++; $display("FAIL overrun first: got %h, want 0001", ovr); end
        wait_frames(1, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL overrun timeout frame1: got no frame, want 1"); end
        tick(10);
        vecs++; if (cs_n !== 1'b0) begin errs++; $display("FAIL overrun frame2 start: got cs_n %b, want 0", cs_n); end
        strobe(16'h4444, 1'b0);
        tick(4);
        strobe(16'h5555, 1'b0);
        vecs++; if (ovr !== 16'd2) begin errs++; $display("FAIL overrun second: got %h, want 0002", ovr); end
        tick(4);
        strobe(16'h6666, 1'b1); expect_frame(16'h6666);
        vecs++; if (ovr !== 16'd1) begin errs++; $display("FAIL overrun clear+overrun: got %h, want 0001", ovr); end
        tick(3);
        clear_overrun = 1'b1; tick(1); clear_overrun = 1'b0;
        vecs++; if (ovr !== 16'd0) begin errs++; $display("FAIL overrun clear: got %h, want 0000", ovr); end
        wait_frames(3, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL overrun timeout: got %0d frames, want 3", rx_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); vecs++;
            if (g !== e) begin errs++; $display("FAIL overrun word: got %h, want %h", g, e); end
        end
        while (exp_ob_q.size() > 0 && rx_ob_q.size() > 0) begin
            e = exp_ob_q.pop_front(); g = rx_ob_q.pop_front(); vecs++;
            if (g !== e) begin errs++; $display("FAIL overrun ob word: got %h, want %h", g, e); end
        end
    endtask

    task automatic test_enable();
        logic [23:0] e, g;
        logic [15:0] ovr0;
        bit ok;
        tick(20); flush(); ovr0 = ovr;
        strobe(16'hA1A1, 1'b0); expect_frame(16'hA1A1);
        tick(3);
        strobe(16'hB2B2, 1'b0); expect_frame(16'hB2B2);
        tick(19);
        enable = 1'b0;
        strobe(16'hC3C3, 1'b0);
        strobe(16'hD4D4, 1'b0);
        vecs++; if (ovr !== ovr0) begin errs++; $display("FAIL enable ignored overrun: got %h, want %h", ovr, ovr0); end
        wait_frames(2, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL enable timeout: got %0d frames, want 2", rx_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); vecs++;
            if (g !== e) begin errs++; $display("FAIL enable word: got %h, want %h", g, e); end
        end
        while (exp_ob_q.size() > 0 && rx_ob_q.size() > 0) begin
            e = exp_ob_q.pop_front(); g = rx_ob_q.pop_front(); vecs++;
            if (g !== e) begin errs++; $display("FAIL enable ob word: got %h, want %h", g, e); end
        end
        tick(20);
        strobe(16'hE5E5, 1'b0);
        tick(150);
        vecs++; if (rx_q.size() != 0) begin errs++; $display("FAIL enable extra frames: got %0d, want 0", rx_q.size()); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL enable busy: got %b, want 0", busy); end
        vecs++; if (ovr !== ovr0) begin errs++; $display("FAIL enable overrun_cnt: got %h, want %h", ovr, ovr0); end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [23:0] e, g;
        bit ok;
        int b, l;
        tick(10); flush();
        strobe(16'hFFFF, 1'b0);
        tick(1);
        tick(52);
        vecs++; if ({sclk, mosi} !== 2'b11) begin errs++; $display("FAIL midreset bit12 sclk/mosi: got %b%b, want 11", sclk, mosi); end
        reset_n = 1'b0;
        #1;
        vecs++; if ({cs_n, sclk, mosi} !== 3'b100) begin
            errs++; $display("FAIL midreset outputs cs_n/sclk/mosi: got %b%b%b, want 100", cs_n, sclk, mosi);
        end
        tick(2);
        reset_n = 1'b1;
        tick(2);
        vecs++; if (rx_q.size() != 0) begin errs++; $display("FAIL midreset partial frame: got %0d frames, want 0", rx_q.size()); end
        flush();
        strobe(16'h1234, 1'b0); expect_frame(16'h1234);
        wait_frames(1, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL midreset timeout: got no frame, want 1"); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); g = rx_q.pop_front(); vecs++;
            if (g !== e) begin errs++; $display("FAIL midreset word: got %h, want %h", g, e); end
        end
        while (exp_ob_q.size() > 0 && rx_ob_q.size() > 0) begin
            e = exp_ob_q.pop_front(); g = rx_ob_q.pop_front(); vecs++;
            if (g !== e) begin errs++; $display("FAIL midreset ob word: got %h, want %h", g, e); end
        end
        if (bits_q.size() > 0) begin
            b = bits_q.pop_front(); l = low_q.pop_front();
            vecs++; if (b != FW) begin errs++; $display("FAIL midreset rises: got %0d, want %0d", b, FW); end
            vecs++; if (l != LOW_CYC) begin errs++; $display("FAIL midreset cs low cycles: got %0d, want %0d", l, LOW_CYC); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_offset();
        test_back_to_back();
        test_overrun();
        test_enable();
        test_reset_mid();
        tick(10);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
